// File: rtl/counter_scheduler.sv
// Two-requester counter scheduler: grants one requester at a time, counts up to
// its latched limit, pulses done, and alternates ownership when both contend.
module counter_scheduler #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic [1:0]    req,
  input  logic [CW-1:0] limit0,
  input  logic [CW-1:0] limit1,
  input  logic          pause,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] lim, lim_nxt;
  logic          done_nxt, done_id_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic          winner;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_nxt   = state;
    grant_nxt   = grant;
    count_nxt   = count;
    lim_nxt     = lim;
    owner_nxt   = owner;
    last_nxt    = last;
    done_nxt    = 1'b0;
    done_id_nxt = done_id;
    winner      = 1'b0;

    unique case (state)
      IDLE: begin
        grant_nxt = 2'b00;
        count_nxt = '0;
        if (req != 2'b00) begin
          // On contention the requester not served last wins.
          winner    = (req == 2'b11) ? ~last : req[1];
          owner_nxt = winner;
          grant_nxt = winner ? 2'b10 : 2'b01;
          lim_nxt   = winner ? limit1 : limit0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          // Abort takes priority over pause.
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          count_nxt = '0;
          last_nxt  = owner;
        end else if (!pause) begin
          if (count == lim) begin
            state_nxt   = DONE;
            done_nxt    = 1'b1;
            done_id_nxt = owner;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        count_nxt = '0;
        last_nxt  = owner;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        count_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= IDLE;
      grant   <= 2'b00;
      busy    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
      lim     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      busy    <= (state_nxt != IDLE);
      count   <= count_nxt;
      done    <= done_nxt;
      done_id <= done_id_nxt;
      lim     <= lim_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a job-level reference model.
module tb_counter_scheduler;

  localparam int CW = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          clear_n;
  logic [1:0]    req;
  logic [CW-1:0] limit0, limit1;
  logic          pause;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] count;
  logic          done;
  logic          done_id;

  int n_checks = 0;
  int n_errors = 0;

  counter_scheduler #(.CW(CW)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .req     (req),
    .limit0  (limit0),
    .limit1  (limit1),
    .pause   (pause),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clock = ~clock;

  // Reference model: who owns the counter (-1 = nobody), how far the job has
  // counted, its target, and whether the job has just finished.
  int m_owner, m_cnt, m_lim, m_last, m_done_id;
  bit m_done, m_finishing;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_lim = 0; m_last = 1;
    m_done_id = 0; m_done = 0; m_finishing = 0;
  endtask

  task automatic model_edge(input logic [1:0] r, input int l0, input int l1, input bit p);
    m_done = 0;
    if (m_finishing) begin
      m_finishing = 0;
      m_last = m_owner;
      m_owner = -1;
      m_cnt = 0;
    end else if (m_owner < 0) begin
      if (r != 2'b00) begin
        m_owner = (r == 2'b11) ? (1 - m_last) : (r == 2'b10 ? 1 : 0);
        m_lim = (m_owner == 1) ? l1 : l0;
        m_cnt = 0;
      end
    end else if (!r[m_owner]) begin
      m_last = m_owner;
      m_owner = -1;
      m_cnt = 0;
    end else if (!p) begin
      if (m_cnt == m_lim) begin
        m_finishing = 1;
        m_done = 1;
        m_done_id = m_owner;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("grant",   32'(grant),   (m_owner < 0) ? 0 : (1 << m_owner));
    check("busy",    32'(busy),    32'(m_owner >= 0));
    check("count",   32'(count),   m_cnt);
    check("done",    32'(done),    32'(m_done));
    check("done_id", 32'(done_id), m_done_id);
  endtask

  // Apply inputs, take one rising edge, then compare away from the edge.
  task automatic step(input logic [1:0] r, input int l0, input int l1, input bit p);
    req = r; limit0 = CW'(l0); limit1 = CW'(l1); pause = p;
    @(posedge clock);
    model_edge(r, l0, l1, p);
    #1;
    compare_all();
  endtask

  // Reset pulse placed between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy",  32'(busy),  0);
    check("rst_count", 32'(count), 0);
    check("rst_done",  32'(done),  0);
    check("rst_id",    32'(done_id), 0);
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  // Step with a fixed request until done is seen; idx is the step index of done or -1.
  task automatic run_until_done(input logic [1:0] r, input int l0, input int l1,
                                input int max_steps, output int idx, output int id);
    idx = -1;
    id = -1;
    for (int i = 0; i < max_steps; i++) begin
      step(r, l0, l1, 1'b0);
      if (done === 1'b1) begin
        idx = i;
        id = done_id;
        break;
      end
    end
    if (idx < 0) check("done_timeout", 32'(max_steps), 0);
  endtask

  initial begin
    int idx, id, max_cnt;
    logic [1:0] r;

    req = 2'b00; limit0 = '0; limit1 = '0; pause = 1'b0; clear_n = 1'b1;
    model_reset();
    @(posedge clock);
    apply_reset();
    step(2'b00, 0, 0, 0);
    step(2'b00, 5, 5, 0);

    // Single request, limit 3: done four steps after the granting edge.
    run_until_done(2'b01, 3, 0, 20, idx, id);
    check("single_done_at", 32'(idx), 4);
    check("single_done_id", 32'(id), 0);
    step(2'b00, 3, 0, 0);
    step(2'b00, 3, 0, 0);

    // Contention after reset: 0, 1, 0 in turn.
    apply_reset();
    run_until_done(2'b11, 1, 2, 20, idx, id);
    check("fair_first", 32'(id), 0);
    run_until_done(2'b11, 1, 2, 20, idx, id);
    check("fair_second", 32'(id), 1);
    run_until_done(2'b11, 1, 2, 20, idx, id);
    check("fair_third", 32'(id), 0);
    step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 0);

    // Pause for three cycles at count 2 delays done by three.
    idx = -1;
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 4, 0, (i >= 3 && i < 6));
      if (done === 1'b1 && idx < 0) idx = i;
      if (done === 1'b1) break;
    end
    check("pause_done_at", 32'(idx), 8);
    step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 0);

    // Limit 0 and full-scale limit.
    run_until_done(2'b01, 0, 0, 10, idx, id);
    check("lim0_done_at", 32'(idx), 1);
    step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    max_cnt = 0;
    idx = -1;
    for (int i = 0; i < 30; i++) begin
      step(2'b10, 0, MAXV, 0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (done === 1'b1) begin
        idx = i;
        break;
      end
    end
    check("full_max_count", 32'(max_cnt), MAXV);
    check("full_done_at", 32'(idx), MAXV + 1);
    step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 0);

    // Abort with pause: requester 0 owns (1 was served last), drops at count 2.
    step(2'b11, 6, 6, 0);
    step(2'b11, 6, 6, 0);
    step(2'b11, 6, 6, 0);
    check("abort_pre_count", 32'(count), 2);
    step(2'b10, 6, 6, 1);
    check("abort_grant", 32'(grant), 0);
    check("abort_done",  32'(done),  0);
    step(2'b10, 6, 6, 0);
    check("abort_next_grant", 32'(grant), 2);
    step(2'b00, 6, 6, 0);
    step(2'b00, 6, 6, 0);

    // Async reset in the middle of a run.
    step(2'b01, 10, 0, 0);
    step(2'b01, 10, 0, 0);
    step(2'b01, 10, 0, 0);
    apply_reset();
    step(2'b00, 0, 0, 0);
    check("post_reset_idle", 32'(busy), 0);

    // Randomized traffic: requests mostly held, occasional pauses and resets.
    r = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) r = 2'($urandom);
      if ($urandom_range(599) == 0) apply_reset();
      else step(r, $urandom_range(MAXV), $urandom_range(MAXV), ($urandom_range(3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
